pwm_gen: RTL and testbench

PWM_GEN -- requirements
Module: pwm_gen

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_gen_if.sv | 22 ++
 rtl/cnt_wrap_det.sv | 28 ++
 rtl/pwm_gen.sv | 97 +++++++++
 tb/tb_pwm_gen.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator: FSM state encodings.
package pwm_pkg;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    typedef enum logic {
        IDLE = STATE_IDLE,
        RUN  = STATE_RUN
    } pwm_state_e;

endpackage

// File: rtl/pwm_gen_if.sv
// Duty-value valid/ready handshake between a duty source and the PWM generator.
interface pwm_gen_if #(
    parameter int width = 4
);

    logic [width-1:0] duty_in;
    logic             duty_valid;
    logic             duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );

endinterface

// File: rtl/cnt_wrap_det.sv
// Registers the upstream count and flags a wrap whenever the count moves backwards.
module cnt_wrap_det #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [width-1:0] cnt,
    output logic             wrap
);

    logic [width-1:0] cnt_q;
    logic [width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap = (cnt < cnt_q);

endmodule

// File: rtl/pwm_gen.sv
// PWM generator: compares an external free-running count against a double-buffered
// duty value; new duty values are staged and swapped in only at a counter wrap.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [width-1:0] cnt,
    input  logic             en,
    pwm_gen_if.slave         duty_if,
    output logic             pwm_out,
    output logic             period_start,
    output logic             update_ack
);

    logic             wrap;
    logic             accept;

    pwm_state_e       state_q, state_d;
    logic [width-1:0] duty_act_q, duty_act_d;
    logic [width-1:0] duty_pend_q, duty_pend_d;
    logic             pend_full_q, pend_full_d;
    logic             pwm_out_q, pwm_out_d;
    logic             period_start_q, period_start_d;
    logic             update_ack_q, update_ack_d;

    cnt_wrap_det #(
        .width (width)
    ) u_wrap_det (
        .clk  (clk),
        .rstn (rstn),
        .cnt  (cnt),
        .wrap (wrap)
    );

    assign accept = duty_if.duty_valid && !pend_full_q;

    always_comb begin
        state_d        = state_q;
        duty_act_d     = duty_act_q;
        duty_pend_d    = duty_pend_q;
        pend_full_d    = pend_full_q;
        pwm_out_d      = 1'b0;
        period_start_d = 1'b0;
        update_ack_d   = 1'b0;

        case (state_q)
            IDLE: if (en)  state_d = RUN;
            RUN:  if (!en) state_d = IDLE;
        endcase

        // Outputs are registered alongside the state, so they follow the state being entered.
        if (state_d == RUN) begin
            pwm_out_d      = (cnt < duty_act_q);
            period_start_d = wrap;
            if (wrap && pend_full_q) begin
                duty_act_d   = duty_pend_q;
                pend_full_d  = 1'b0;
                update_ack_d = 1'b1;
            end
        end

        // Acceptance needs an empty slot, so it can never collide with the swap above.
        if (accept) begin
            duty_pend_d = duty_if.duty_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            duty_act_q     <= '0;
            duty_pend_q    <= '0;
            pend_full_q    <= 1'b0;
            pwm_out_q      <= 1'b0;
            period_start_q <= 1'b0;
            update_ack_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            duty_act_q     <= duty_act_d;
            duty_pend_q    <= duty_pend_d;
            pend_full_q    <= pend_full_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
            update_ack_q   <= update_ack_d;
        end
    end

    assign pwm_out            = pwm_out_q;
    assign period_start       = period_start_q;
    assign update_ack         = update_ack_q;
    assign duty_if.duty_ready = ~pend_full_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: directed scenarios plus randomized traffic against a behavioural model.
module tb_pwm_gen;

    localparam int W = 4;

    logic         clk  = 1'b0;
    logic         rstn = 1'b1;
    logic         en   = 1'b0;
    logic [W-1:0] cnt  = '0;
    logic         pwm_out, period_start, update_ack;

    pwm_gen_if #(.width(W)) duty_if ();

    pwm_gen #(.width(W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cnt          (cnt),
        .en           (en),
        .duty_if      (duty_if),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .update_ack   (update_ack)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: active duty, staged duty and the previous count.
    logic [W-1:0] m_cntq, m_act, m_pend;
    logic         m_full, e_pwm, e_ps, e_ack;
    logic [3:0]   obs, expv;

    assign obs  = {pwm_out, period_start, update_ack, duty_if.duty_ready};
    assign expv = {e_pwm, e_ps, e_ack, ~m_full};

    task automatic model_reset();
        m_cntq = '0;
        m_act  = '0;
        m_pend = '0;
        m_full = 1'b0;
        e_pwm  = 1'b0;
        e_ps   = 1'b0;
        e_ack  = 1'b0;
    endtask

    task automatic model_step();
        logic wrapped, taken;
        wrapped = (cnt < m_cntq);
        taken   = duty_if.duty_valid && !m_full;
        e_pwm = 1'b0;
        e_ps  = 1'b0;
        e_ack = 1'b0;
        if (en) begin
            e_pwm = (cnt < m_act);
            e_ps  = wrapped;
            if (wrapped && m_full) begin
                m_act  = m_pend;
                m_full = 1'b0;
                e_ack  = 1'b1;
            end
        end
        if (taken) begin
            m_pend = duty_if.duty_in;
            m_full = 1'b1;
            $display("txn cycle %0d: duty %0d loaded (en=%0b)", cyc, duty_if.duty_in, en);
        end
        m_cntq = cnt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        duty_if.duty_valid = 1'b0;
        duty_if.duty_in    = '0;
        #1 rstn = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (obs !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_async: got %b want 0001", obs);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_duty4();
        int  highs;
        bit  seen;
        en = 1'b1;
        duty_if.duty_in    = W'(4);
        duty_if.duty_valid = 1'b1;
        cnt = cnt + 1'b1;
        tick();
        duty_if.duty_valid = 1'b0;
        n_vec++;
        if (duty_if.duty_ready !== 1'b0) begin
            n_err++;
            $display("FAIL duty4_ready_low: got %b want 0", duty_if.duty_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cnt = cnt + 1'b1;
            tick();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL duty4_run cyc %0d: got %b want %b", cyc, obs, expv);
            end
            if (update_ack) begin
                seen = 1'b1;
                n_vec++;
                if (period_start !== 1'b1) begin
                    n_err++;
                    $display("FAIL duty4_ack_with_ps: period_start %b want 1", period_start);
                end
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL duty4_ack_timeout: update_ack 0 want 1 within 40 cycles");
        end
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 1'b1;
            tick();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL duty4_period cyc %0d: got %b want %b", cyc, obs, expv);
            end
            highs += int'(pwm_out);
        end
        n_vec++;
        if (highs != 4) begin
            n_err++;
            $display("FAIL duty4_high_count: got %0d want 4", highs);
        end
    endtask

    task automatic test_boundary();
        logic [W-1:0] duties [2];
        int           want   [2];
        int           highs;
        bit           seen;
        duties[0] = '0;          want[0] = 0;
        duties[1] = {W{1'b1}};   want[1] = 30;
        for (int k = 0; k < 2; k++) begin
            duty_if.duty_in    = duties[k];
            duty_if.duty_valid = 1'b1;
            cnt = cnt + 1'b1;
            tick();
            duty_if.duty_valid = 1'b0;
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL bnd_load cyc %0d: got %b want %b", cyc, obs, expv);
            end
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                cnt = cnt + 1'b1;
                tick();
                n_vec++;
                if (obs !== expv) begin
                    n_err++;
                    $display("FAIL bnd_wait cyc %0d: got %b want %b", cyc, obs, expv);
                end
                if (update_ack) seen = 1'b1;
            end
            n_vec++;
            if (!seen) begin
                n_err++;
                $display("FAIL bnd_ack_timeout duty %0d: update_ack 0 want 1", duties[k]);
            end
            highs = 0;
            for (int i = 0; i < 32; i++) begin
                cnt = cnt + 1'b1;
                tick();
                n_vec++;
                if (obs !== expv) begin
                    n_err++;
                    $display("FAIL bnd_run cyc %0d: got %b want %b", cyc, obs, expv);
                end
                highs += int'(pwm_out);
            end
            n_vec++;
            if (highs != want[k]) begin
                n_err++;
                $display("FAIL bnd_high_count duty %0d: got %0d want %0d", duties[k], highs, want[k]);
            end
        end
    endtask

    task automatic test_handshake();
        int acks, ack1_cyc, acc9_cyc;
        bit will_take;
        for (int i = 0; i < 4; i++) begin
            cnt = cnt + 1'b1;
            tick();
        end
        duty_if.duty_in    = W'(3);
        duty_if.duty_valid = 1'b1;
        cnt = cnt + 1'b1;
        tick();
        duty_if.duty_in = W'(9);
        acks     = 0;
        ack1_cyc = -1;
        acc9_cyc = -1;
        for (int i = 0; i < 60 && acks < 2; i++) begin
            will_take = duty_if.duty_valid && !m_full;
            cnt = cnt + 1'b1;
            tick();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL hs_run cyc %0d: got %b want %b", cyc, obs, expv);
            end
            if (will_take) begin
                acc9_cyc = cyc;
                duty_if.duty_valid = 1'b0;
            end
            if (update_ack) begin
                acks++;
                if (acks == 1) ack1_cyc = cyc;
            end
        end
        n_vec++;
        if (acks != 2) begin
            n_err++;
            $display("FAIL hs_ack_count: got %0d want 2", acks);
        end
        n_vec++;
        if (acc9_cyc != ack1_cyc + 1 || ack1_cyc < 0) begin
            n_err++;
            $display("FAIL hs_second_accept: accepted cyc %0d want %0d", acc9_cyc, ack1_cyc + 1);
        end
    endtask

    task automatic test_wrap_transfer();
        for (int i = 0; i < 16 && cnt != {W{1'b1}}; i++) begin
            cnt = cnt + 1'b1;
            tick();
        end
        cnt = '0;
        duty_if.duty_in    = W'(7);
        duty_if.duty_valid = 1'b1;
        tick();
        duty_if.duty_valid = 1'b0;
        n_vec++;
        if (update_ack !== 1'b0 || period_start !== 1'b1) begin
            n_err++;
            $display("FAIL wt_wrap_no_ack: ack/ps got %b%b want 01", update_ack, period_start);
        end
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 1'b1;
            tick();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL wt_run cyc %0d: got %b want %b", cyc, obs, expv);
            end
            if (i == 15) begin
                n_vec++;
                if (update_ack !== 1'b1) begin
                    n_err++;
                    $display("FAIL wt_next_wrap_ack: got %b want 1", update_ack);
                end
            end
        end
    endtask

    task automatic test_enable();
        int ps_seen, ack_seen;
        for (int i = 0; i < 3; i++) begin
            cnt = cnt + 1'b1;
            tick();
        end
        en = 1'b0;
        cnt = cnt + 1'b1;
        tick();
        n_vec++;
        if (pwm_out !== 1'b0) begin
            n_err++;
            $display("FAIL en_off_pwm: got %b want 0", pwm_out);
        end
        duty_if.duty_in    = W'(2);
        duty_if.duty_valid = 1'b1;
        cnt = cnt + 1'b1;
        tick();
        duty_if.duty_valid = 1'b0;
        ps_seen  = 0;
        ack_seen = 0;
        for (int i = 0; i < 36; i++) begin
            if (i >= 20 && cnt == W'(5)) break;
            cnt = cnt + 1'b1;
            tick();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL en_idle cyc %0d: got %b want %b", cyc, obs, expv);
            end
            ps_seen  += int'(period_start);
            ack_seen += int'(update_ack);
        end
        n_vec++;
        if (ps_seen != 0 || ack_seen != 0) begin
            n_err++;
            $display("FAIL en_idle_quiet: ps %0d ack %0d want 0 0", ps_seen, ack_seen);
        end
        en = 1'b1;
        cnt = W'(6);
        tick();
        n_vec++;
        if (pwm_out !== 1'b1) begin
            n_err++;
            $display("FAIL en_resume_pwm: got %b want 1", pwm_out);
        end
        for (int i = 0; i < 20; i++) begin
            cnt = cnt + 1'b1;
            tick();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL en_resume cyc %0d: got %b want %b", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        en = 1'b1;
        duty_if.duty_in    = W'(11);
        duty_if.duty_valid = 1'b1;
        cnt = cnt + 1'b1;
        tick();
        duty_if.duty_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (obs !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_mid_async: got %b want 0001", obs);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (obs !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_mid_hold: got %b want 0001", obs);
        end
        rstn = 1'b1;
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            cnt = cnt + 1'b1;
            tick();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL rst_after cyc %0d: got %b want %b", cyc, obs, expv);
            end
            acks += int'(update_ack);
        end
        n_vec++;
        if (acks != 0) begin
            n_err++;
            $display("FAIL rst_no_ack: got %0d acks want 0", acks);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) cnt = W'($urandom);
            else                            cnt = cnt + 1'b1;
            duty_if.duty_valid = ($urandom_range(0, 3) == 0);
            duty_if.duty_in    = W'($urandom);
            tick();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b want %b", cyc, obs, expv);
            end
        end
        duty_if.duty_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_duty4();
        test_boundary();
        test_handshake();
        test_wrap_transfer();
        test_enable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
